// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - Wishbone interrupt controller: pending/mask/vector/mode registers, lowest-index priority
// Optional macro IRQ_CTRL_SYNC_EN adds a two-flop synchronizer ahead of the input register.
module irq_ctrl #(
    parameter int NIRQ = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic            we_i,
    input  logic [1:0]      adr_i,
    input  logic [3:0]      sel_i,
    input  logic [31:0]     dat_i,
    output logic [31:0]     dat_o,
    output logic            ack_o,
    input  logic [NIRQ-1:0] irq_i,
    output logic            irq_o,
    output logic [2:0]      irq_num_o
);

    localparam logic [1:0] ADR_PENDING = 2'd0;
    localparam logic [1:0] ADR_MASK    = 2'd1;
    localparam logic [1:0] ADR_VECTOR  = 2'd2;
    localparam logic [1:0] ADR_MODE    = 2'd3;

    logic            req;
    logic            wr_en;
    logic [NIRQ-1:0] irq_src;
    logic [NIRQ-1:0] irq_s;
    logic [NIRQ-1:0] irq_d;
    logic [1:0]      prime;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] w1c;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] pending_nxt;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] mode;
    logic [NIRQ-1:0] active;
    logic [2:0]      prio_num;
    logic [31:0]     rd_data;
    logic            unused_bits;

    assign unused_bits = ^{sel_i[3:1], dat_i[31:NIRQ]};

    // A strobe held across an ack is ignored for that cycle, giving one ack every second cycle.
    assign req   = cyc_i & stb_i & ~ack_o;
    assign wr_en = req & we_i & sel_i[0];

`ifdef IRQ_CTRL_SYNC_EN
    logic [NIRQ-1:0] sync_q1;
    logic [NIRQ-1:0] sync_q2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_i;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_src = sync_q2;
`else
    assign irq_src = irq_i;
`endif

    // prime[1] stays low until irq_d holds a real sample, so a level present
    // straight out of reset is not mistaken for a rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_s <= '0;
            irq_d <= '0;
            prime <= '0;
        end else begin
            irq_s <= irq_src;
            irq_d <= irq_s;
            prime <= {prime[0], 1'b1};
        end
    end

    assign rise = irq_s & ~irq_d & {NIRQ{prime[1]}};
    assign w1c  = (wr_en && adr_i == ADR_PENDING) ? dat_i[NIRQ-1:0] : '0;

    // Edge bits: set beats clear. Level bits simply track irq_s and ignore W1C.
    assign pending_nxt = (mode & ((pending & ~w1c) | rise)) | (~mode & irq_s);
    assign active      = pending & mask;

    always_comb begin
        prio_num = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                prio_num = 3'(i);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (adr_i)
            ADR_PENDING: rd_data[NIRQ-1:0] = pending;
            ADR_MASK:    rd_data[NIRQ-1:0] = mask;
            ADR_VECTOR:  rd_data = {irq_o, 28'd0, irq_num_o};
            ADR_MODE:    rd_data[NIRQ-1:0] = mode;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending   <= '0;
            mask      <= '0;
            mode      <= '0;
            irq_o     <= 1'b0;
            irq_num_o <= '0;
            ack_o     <= 1'b0;
            dat_o     <= '0;
        end else begin
            pending   <= pending_nxt;
            irq_o     <= |active;
            irq_num_o <= prio_num;
            ack_o     <= req;
            if (req) begin
                dat_o <= rd_data;
            end
            if (wr_en && adr_i == ADR_MASK) begin
                mask <= dat_i[NIRQ-1:0];
            end
            if (wr_en && adr_i == ADR_MODE) begin
                mode <= dat_i[NIRQ-1:0];
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl with directed vectors
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [5:0]  irq_i;
    logic        irq_o;
    logic [2:0]  irq_num_o;

    always #5 clk = ~clk;

    irq_ctrl #(.NIRQ(6)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .sel_i     (sel_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .irq_i     (irq_i),
        .irq_o     (irq_o),
        .irq_num_o (irq_num_o)
    );

    int n_vec = 0;
    int n_err = 0;
    logic probe = 1'b0;

    string       rd_name_q[$];
    logic [31:0] rd_exp_q[$];
    bit          rd_chk_q[$];
    string       pr_name_q[$];
    logic [3:0]  pr_exp_q[$];

    string       m_name;
    logic [31:0] m_exp;
    bit          m_chk;
    logic [3:0]  m_pexp;

    // Monitor: bus responses popped on every ack, irq outputs popped on probe cycles.
    always @(negedge clk) begin
        if (ack_o) begin
            if (rd_name_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: ack_o=1 with no transfer outstanding");
            end else begin
                m_name = rd_name_q.pop_front();
                m_exp  = rd_exp_q.pop_front();
                m_chk  = rd_chk_q.pop_front();
                if (m_chk) begin
                    n_vec++;
                    if (dat_o !== m_exp) begin
                        n_err++;
                        $display("FAIL %s: dat_o=%08h expected %08h", m_name, dat_o, m_exp);
                    end
                end
            end
        end
        if (probe) begin
            while (pr_name_q.size() > 0) begin
                m_name = pr_name_q.pop_front();
                m_pexp = pr_exp_q.pop_front();
                n_vec++;
                if ({irq_o, irq_num_o} !== m_pexp) begin
                    n_err++;
                    $display("FAIL %s: irq_o=%b irq_num_o=%0d expected irq_o=%b irq_num_o=%0d",
                             m_name, irq_o, irq_num_o, m_pexp[3], m_pexp[2:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic chk(input string nm, input logic io, input logic [2:0] num);
        pr_name_q.push_back(nm);
        pr_exp_q.push_back({io, num});
        probe = 1'b1;
    endtask

    // Returns in the cycle where ack_o is high; the write has just taken effect.
    task automatic bus_nostep(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                              input string nm, input logic [31:0] exp);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        sel_i = 4'h1;
        dat_i = wd;
        rd_name_q.push_back(nm);
        rd_exp_q.push_back(exp);
        rd_chk_q.push_back(!we);
        step();
        n_vec++;
        if (ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ack_latency: ack_o=%b expected 1", nm, ack_o);
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        dat_i = '0;
    endtask

    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                       input string nm, input logic [31:0] exp);
        bus_nostep(we, adr, wd, nm, exp);
        step();
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] wd, input string nm);
        bus(1'b1, adr, wd, nm, 32'h0);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string nm);
        bus(1'b0, adr, 32'h0, nm, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        adr_i = '0;
        sel_i = '0;
        dat_i = '0;
        irq_i = '0;
        step();
        step();
        rst_i = 1'b0;
        chk("reset_irq", 1'b0, 3'd0);

        // Reset values of every register
        rd(2'd0, 32'h0000_0000, "reset_pending");
        rd(2'd1, 32'h0000_0000, "reset_mask");
        rd(2'd2, 32'h0000_0000, "reset_vector");
        rd(2'd3, 32'h0000_0000, "reset_mode");

        // Edge mode, single pulse on irq 4: three clocks to irq_o
        wr(2'd3, 32'hFFFF_FF3F, "wr_mode");
        wr(2'd1, 32'h0000_003F, "wr_mask");
        rd(2'd3, 32'h0000_003F, "mode_upper_zero");
        irq_i = 6'h10;
        step();
        irq_i = 6'h00;
        chk("edge_lat1", 1'b0, 3'd0);
        step();
        chk("edge_lat2", 1'b0, 3'd0);
        step();
        chk("edge_lat3", 1'b1, 3'd4);
        rd(2'd2, 32'h8000_0004, "vector_4");
        rd(2'd0, 32'h0000_0010, "pending_10");

        // Masking keeps PENDING; unmasking raises irq_o one clock later
        bus_nostep(1'b1, 2'd1, 32'h0, "mask_off", 32'h0);
        chk("mask_off_same", 1'b1, 3'd4);
        step();
        chk("mask_off_next", 1'b0, 3'd0);
        rd(2'd0, 32'h0000_0010, "pending_kept");
        bus_nostep(1'b1, 2'd1, 32'h3F, "mask_on", 32'h0);
        chk("mask_on_same", 1'b0, 3'd0);
        step();
        chk("mask_on_next", 1'b1, 3'd4);

        // Priority between irq 1 and irq 4, cleared one by one
        irq_i = 6'h02;
        step();
        irq_i = 6'h00;
        step();
        step();
        chk("prio_1", 1'b1, 3'd1);
        rd(2'd0, 32'h0000_0012, "pending_12");
        wr(2'd0, 32'h0000_0002, "w1c_02");
        chk("prio_4_after_w1c", 1'b1, 3'd4);
        wr(2'd0, 32'h0000_0010, "w1c_10");
        chk("all_clear", 1'b0, 3'd0);

        // Edge set on irq 2 collides with W1C of bit 2: set wins
        irq_i = 6'h04;
        step();
        irq_i = 6'h00;
        wr(2'd0, 32'h0000_0004, "w1c_collide");
        rd(2'd0, 32'h0000_0004, "set_wins");
        wr(2'd0, 32'h0000_0004, "w1c_04");
        rd(2'd0, 32'h0000_0000, "pending_empty");

        // Level mode on irq 0
        wr(2'd3, 32'h0000_0000, "wr_mode_level");
        wr(2'd1, 32'h0000_0000, "wr_mask_0");
        irq_i = 6'h01;
        step();
        step();
        step();
        chk("level_masked", 1'b0, 3'd0);
        rd(2'd0, 32'h0000_0001, "level_pending");
        bus_nostep(1'b1, 2'd1, 32'h0000_0001, "level_unmask", 32'h0);
        chk("level_unmask_same", 1'b0, 3'd0);
        step();
        chk("level_unmask_next", 1'b1, 3'd0);
        wr(2'd0, 32'h0000_0001, "level_w1c");
        rd(2'd0, 32'h0000_0001, "level_w1c_ignored");
        chk("level_still_active", 1'b1, 3'd0);

        // Reset lands on the edge that would have acked a MASK write
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        adr_i = 2'd1;
        sel_i = 4'h1;
        dat_i = 32'h0000_003F;
        rst_i = 1'b1;
        irq_i = 6'h00;
        step();
        n_vec++;
        if (ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ack: ack_o=%b expected 0", ack_o);
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        dat_i = '0;
        rst_i = 1'b0;
        chk("abort_irq", 1'b0, 3'd0);
        step();
        n_vec++;
        if (ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ack_late: ack_o=%b expected 0", ack_o);
        end
        rd(2'd0, 32'h0000_0000, "abort_pending");
        rd(2'd1, 32'h0000_0000, "abort_mask");
        rd(2'd2, 32'h0000_0000, "abort_vector");
        rd(2'd3, 32'h0000_0000, "abort_mode");

        step();
        step();
        n_vec++;
        if (rd_name_q.size() != 0 || pr_name_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d bus and %0d probe entries left, expected 0",
                     rd_name_q.size(), pr_name_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
